// File: rtl/uart_link_pkg.sv
// uart_link_pkg: shared types and constants for the 8N1 UART endpoint.
//   tx_state_e / rx_state_e : transmitter and receiver FSM states
//   uart_div()              : clocks per bit from clock frequency and baud rate
//   START_BIT, STOP_BIT, DATA_BITS : frame format constants
package uart_link_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  localparam logic        START_BIT = 1'b0;
  localparam logic        STOP_BIT  = 1'b1;
  localparam int unsigned DATA_BITS = 8;

  function automatic int unsigned uart_div(input int unsigned clk_freq,
                                           input int unsigned baudrate);
    return clk_freq / baudrate;
  endfunction

endpackage

// File: rtl/uart_link_rx.sv
// uart_link_rx: 8N1 receiver with input synchronizer and 1-entry holding register.
//   clk_i, rst_ni          : clock, async active-low reset
//   rxd_i                  : serial input (asynchronous to clk_i)
//   rx_data_o, rx_valid_o  : received byte and its valid flag
//   rx_ready_i             : consumer accepts the held byte
//   rx_frame_err_o         : 1-cycle pulse, stop bit sampled low
//   rx_overrun_o           : 1-cycle pulse, byte dropped because holding register full
module uart_link_rx
  import uart_link_pkg::*;
#(
  parameter int unsigned DIV = 60
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rxd_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       rx_frame_err_o,
  output logic       rx_overrun_o
);

  localparam int unsigned DIV_W = $clog2(DIV + 1);

  logic                 sync1_q, sync2_q, prev_q;
  rx_state_e            state_q, state_d;
  logic [DIV_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [7:0]           data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 sample;
  logic                 deliver;

  // Down-counter: zero marks the sampling point of the current bit.
  assign sample = (cnt_q == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // Synchronizer resets to the idle line level so reset release is not seen as a start edge.
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync1_q <= rxd_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    deliver = 1'b0;

    if (state_q != RX_IDLE && state_q != RX_WAIT_HIGH) begin
      cnt_d = sample ? DIV_W'(DIV - 1) : cnt_q - DIV_W'(1);
    end

    case (state_q)
      RX_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = RX_START;
          cnt_d   = DIV_W'(DIV / 2 - 1);
        end
      end
      RX_START: begin
        if (sample) begin
          if (sync2_q != START_BIT) begin
            state_d = RX_IDLE;
          end else begin
            state_d = RX_DATA;
            bit_d   = '0;
          end
        end
      end
      RX_DATA: begin
        if (sample) begin
          shift_d = {sync2_q, shift_q[DATA_BITS-1:1]};
          if (bit_q == 3'(DATA_BITS - 1)) begin
            state_d = RX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      RX_STOP: begin
        if (sample) begin
          if (sync2_q == STOP_BIT) begin
            state_d = RX_IDLE;
            deliver = 1'b1;
          end else begin
            state_d = RX_WAIT_HIGH;
            ferr_d  = 1'b1;
          end
        end
      end
      RX_WAIT_HIGH: begin
        if (sync2_q) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase

    // A delivery may reuse the slot being consumed in the same cycle.
    if (deliver) begin
      if (!valid_q || rx_ready_i) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && rx_ready_i) begin
      valid_d = 1'b0;
    end
  end

  assign rx_data_o      = data_q;
  assign rx_valid_o     = valid_q;
  assign rx_frame_err_o = ferr_q;
  assign rx_overrun_o   = ovr_q;

endmodule

// File: rtl/uart_link.sv
// uart_link: host-side 8N1 UART endpoint, full duplex, valid/ready byte streams.
//   clk_i, rst_ni                      : clock, async active-low reset
//   txd_o                              : serial out, idle high
//   rxd_i                              : serial in, asynchronous
//   tx_data_i, tx_valid_i, tx_ready_o  : transmit byte stream
//   rx_data_o, rx_valid_o, rx_ready_i  : receive byte stream
//   rx_frame_err_o, rx_overrun_o       : 1-cycle receive error pulses
module uart_link
  import uart_link_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 60000000,
  parameter int unsigned BAUDRATE = 1000000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic       txd_o,
  input  logic       rxd_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       rx_frame_err_o,
  output logic       rx_overrun_o
);

  localparam int unsigned DIV   = uart_div(CLK_FREQ, BAUDRATE);
  localparam int unsigned DIV_W = $clog2(DIV + 1);

  if (DIV < 8) begin : g_div_check
    $error("uart_link: CLK_FREQ/BAUDRATE must be at least 8");
  end

  tx_state_e            tx_state_q, tx_state_d;
  logic [DIV_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_wrap;

  assign tx_wrap = (tx_cnt_q == DIV_W'(DIV - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  // txd_o is decoded from state so an async reset forces the line high at once.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_ready_o = 1'b0;
    txd_o      = STOP_BIT;

    if (tx_state_q != TX_IDLE) begin
      tx_cnt_d = tx_wrap ? '0 : tx_cnt_q + DIV_W'(1);
    end

    case (tx_state_q)
      TX_IDLE: tx_ready_o = 1'b1;
      TX_START: begin
        txd_o = START_BIT;
        if (tx_wrap) begin
          tx_state_d = TX_DATA;
          tx_bit_d   = '0;
        end
      end
      TX_DATA: begin
        txd_o = tx_shift_q[0];
        if (tx_wrap) begin
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == 3'(DATA_BITS - 1)) begin
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end
      end
      TX_STOP: begin
        txd_o = STOP_BIT;
        // Ready in the last stop cycle allows gapless back-to-back frames.
        if (tx_wrap) begin
          tx_ready_o = 1'b1;
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    if (tx_ready_o && tx_valid_i) begin
      tx_shift_d = tx_data_i;
      tx_state_d = TX_START;
      tx_cnt_d   = '0;
    end
  end

  uart_link_rx #(
    .DIV(DIV)
  ) u_rx (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .rxd_i         (rxd_i),
    .rx_data_o     (rx_data_o),
    .rx_valid_o    (rx_valid_o),
    .rx_ready_i    (rx_ready_i),
    .rx_frame_err_o(rx_frame_err_o),
    .rx_overrun_o  (rx_overrun_o)
  );

endmodule

// File: tb/tb_uart_link.sv
// tb_uart_link: self-checking bench for uart_link at DIV=60 (60 MHz / 1 Mbaud).
module tb_uart_link;

  localparam int DIV = 60;

  logic       clk;
  logic       rst_n;
  logic       txd;
  logic       rxd;
  logic       rxd_drv;
  logic       loop_en;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_ferr;
  logic       rx_ovr;

  int n_checks = 0;
  int n_errors = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  logic [31:0] exp_q[$];

  assign rxd = loop_en ? txd : rxd_drv;

  uart_link #(
    .CLK_FREQ(60000000),
    .BAUDRATE(1000000)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .txd_o         (txd),
    .rxd_i         (rxd),
    .tx_data_i     (tx_data),
    .tx_valid_i    (tx_valid),
    .tx_ready_o    (tx_ready),
    .rx_data_o     (rx_data),
    .rx_valid_o    (rx_valid),
    .rx_ready_i    (rx_ready),
    .rx_frame_err_o(rx_ferr),
    .rx_overrun_o  (rx_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected line level in cycle c (1..10*DIV) after a handshake of byte b.
  function automatic logic exp_txd(input logic [7:0] b, input int c);
    if (c <= DIV) return 1'b0;
    if (c <= 9 * DIV) return b[(c - 1) / DIV - 1];
    return 1'b1;
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd_drv = f[i];
      repeat (DIV) @(negedge clk);
    end
  endtask

  // Scoreboard: every consumed byte is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_ferr) ferr_cnt++;
      if (rx_ovr) ovr_cnt++;
      if (rx_valid && rx_ready) begin
        logic [31:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h100;
        check("rx_data", 32'(rx_data), e);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst_n    = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    rxd_drv  = 1'b1;
    loop_en  = 1'b0;
    rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_ferr", 32'(rx_ferr), 32'd0);
    check("rst_ovr", 32'(rx_ovr), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single byte 0xA5
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    for (int c = 1; c <= 10 * DIV; c++) begin
      @(negedge clk);
      if (c == 1) tx_valid = 1'b0;
      check("tx_a5_txd", 32'(txd), 32'(exp_txd(8'hA5, c)));
      check("tx_a5_ready", 32'(tx_ready), 32'(c == 10 * DIV));
    end
    repeat (5) @(negedge clk);

    // Back-to-back 0x00 then 0xFF, valid held
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    for (int c = 1; c <= 20 * DIV; c++) begin
      @(negedge clk);
      if (c == 1) tx_data = 8'hFF;
      if (c == 10 * DIV + 1) tx_valid = 1'b0;
      check("tx_b2b_txd", 32'(txd),
            32'((c <= 10 * DIV) ? exp_txd(8'h00, c) : exp_txd(8'hFF, c - 10 * DIV)));
      check("tx_b2b_ready", 32'(tx_ready), 32'(c == 10 * DIV || c == 20 * DIV));
    end
    repeat (5) @(negedge clk);

    // Loopback 0x3C: start bit on the line in cycle 1, valid at 1 + 2 + 30 + 540 + 1
    loop_en = 1'b1;
    exp_q.push_back(32'h3C);
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    lat = -1;
    for (int c = 1; c <= 700; c++) begin
      @(negedge clk);
      if (c == 1) tx_valid = 1'b0;
      if (rx_valid && lat < 0) lat = c;
    end
    check("lb_latency", 32'(lat), 32'd574);
    check("lb_drained", 32'(exp_q.size()), 32'd0);
    loop_en = 1'b0;
    repeat (10) @(negedge clk);

    // Glitch shorter than half a bit
    rxd_drv = 1'b0;
    repeat (20) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (700) @(negedge clk);
    check("gl_valid", 32'(rx_valid), 32'd0);
    check("gl_ferr", 32'(ferr_cnt), 32'd0);
    check("gl_ovr", 32'(ovr_cnt), 32'd0);

    // Framing error then a good frame
    send_frame(8'h55, 1'b0);
    repeat (100) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (120) @(negedge clk);
    check("fe_pulse", 32'(ferr_cnt), 32'd1);
    check("fe_valid", 32'(rx_valid), 32'd0);
    exp_q.push_back(32'h12);
    send_frame(8'h12, 1'b1);
    repeat (120) @(negedge clk);
    check("fe_good_rx", 32'(exp_q.size()), 32'd0);
    check("fe_pulse_after", 32'(ferr_cnt), 32'd1);

    // Overrun: second byte dropped, first kept
    rx_ready = 1'b0;
    exp_q.push_back(32'h01);
    send_frame(8'h01, 1'b1);
    repeat (DIV) @(negedge clk);
    send_frame(8'h02, 1'b1);
    repeat (120) @(negedge clk);
    check("ov_valid", 32'(rx_valid), 32'd1);
    check("ov_data", 32'(rx_data), 32'h01);
    check("ov_pulse", 32'(ovr_cnt), 32'd1);
    check("ov_no_ferr", 32'(ferr_cnt), 32'd1);
    rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("ov_drained", 32'(exp_q.size()), 32'd0);
    check("ov_consumed", 32'(rx_valid), 32'd0);

    // Asynchronous reset in the middle of a frame
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (200) @(negedge clk);
    check("ar_pre_txd", 32'(txd), 32'd0);
    check("ar_pre_ready", 32'(tx_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("ar_txd", 32'(txd), 32'd1);
    check("ar_ready", 32'(tx_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("ar_post_txd", 32'(txd), 32'd1);
    check("ar_post_ready", 32'(tx_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
